// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU operation codes and the multiply/divide sequencer state type.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b0011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// MULTU/DIVU sequencer: 32-iteration shift-add multiply or restoring divide,
// borrowing the shared datapath ALU for one add/subtract per cycle.
module alu_muldiv_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_operation,
  output logic [4:0]       shmt,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  muldiv_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;   // acc for MULTU, rem for DIVU
  logic [WIDTH-1:0] r_mq;    // mq for MULTU, q for DIVU
  logic [WIDTH-1:0] r_opnd;  // mcand for MULTU, dvsr for DIVU
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_sh;
  logic             w_ovf;
  logic             w_carry;
  logic             w_take;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_mq_nxt;

  // One iteration of the active algorithm, using the ALU result of this cycle.
  always_comb begin
    w_sh      = {r_acc[WIDTH-2:0], r_mq[WIDTH-1]};
    w_ovf     = r_acc[WIDTH-1];
    w_carry   = (alu_out < r_acc);
    w_take    = w_ovf | ~(w_sh < r_opnd);
    w_acc_nxt = r_acc;
    w_mq_nxt  = r_mq;
    case (r_state)
      MUL: begin
        if (r_mq[0]) {w_acc_nxt, w_mq_nxt} = {w_carry, alu_out, r_mq[WIDTH-1:1]};
        else         {w_acc_nxt, w_mq_nxt} = {1'b0, r_acc, r_mq[WIDTH-1:1]};
      end
      DIV: begin
        if (w_take) begin
          w_acc_nxt = alu_out;
          w_mq_nxt  = {r_mq[WIDTH-2:0], 1'b1};
        end else begin
          w_acc_nxt = w_sh;
          w_mq_nxt  = {r_mq[WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // The ALU path must stay combinational so alu_out lands in the same cycle.
  always_comb begin
    alu_in1       = '0;
    alu_in2       = '0;
    alu_operation = ALU_ADD;
    case (r_state)
      MUL: begin
        alu_in1 = r_acc;
        alu_in2 = r_opnd;
      end
      DIV: begin
        alu_in1       = w_sh;
        alu_in2       = r_opnd;
        alu_operation = ALU_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc  <= '0;
            r_mq   <= a;
            r_opnd <= b;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (op_div && (b == '0)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_hi    <= a;
              r_lo    <= '1;
            end else begin
              r_state <= op_div ? DIV : MUL;
            end
          end
        end
        MUL, DIV: begin
          r_acc <= w_acc_nxt;
          r_mq  <= w_mq_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_ITER) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_hi    <= w_acc_nxt;
            r_lo    <= w_mq_nxt;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign shmt = 5'd0;

endmodule
